// File: rtl/dbg_bridge_pkg.sv
// Shared types and protocol constants for the UART-to-Wishbone debug bridge.
// Command/response byte values and state encodings live here so phy and top agree.
package dbg_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WB,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_READ) || (b == CMD_WRITE);
    endfunction

endpackage

// File: rtl/dbg_uart_phy.sv
// 8N1 UART serialiser pair: mid-bit sampling receiver with frame-error flag,
// and a transmitter that accepts the next byte in the last cycle of a stop bit.
module dbg_uart_phy
    import dbg_bridge_pkg::*;
#(
    parameter int CLK_DIV = 104
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    output logic       o_rx_ferr,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_busy,
    output logic       o_tx
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    logic [1:0]    r_rx_sync;
    logic          r_rx_prev;
    rx_state_t     r_rx_state;
    rx_state_t     w_rx_next;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          r_rx_valid;
    logic          r_rx_ferr;
    logic          w_rx;
    logic          w_rx_last;

    logic          r_tx;
    logic          r_tx_busy;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_nbit;
    logic [8:0]    r_tx_shift;
    logic          w_tx_last;
    logic          w_tx_load;

    assign w_rx       = r_rx_sync[1];
    assign o_rx_valid = r_rx_valid;
    assign o_rx_ferr  = r_rx_ferr;
    assign o_rx_data  = r_rx_shift;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    // The start bit is rechecked half a bit in; every later sample is one full bit apart.
    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_last = (r_rx_state == RX_START) ? (r_rx_cnt == HALF_LAST) : (r_rx_cnt == DIV_LAST);
        case (r_rx_state)
            RX_IDLE:  if (!w_rx && r_rx_prev) w_rx_next = RX_START;
            RX_START: if (w_rx_last) w_rx_next = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_last && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_last) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_sync  <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_sync  <= {r_rx_sync[0], i_rx};
            r_rx_prev  <= w_rx;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            if ((r_rx_state == RX_IDLE) || w_rx_last) begin
                r_rx_cnt <= '0;
            end else begin
                r_rx_cnt <= r_rx_cnt + CW'(1);
            end
            if (r_rx_state == RX_START) begin
                r_rx_bit <= '0;
            end
            if ((r_rx_state == RX_DATA) && w_rx_last) begin
                r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
            if ((r_rx_state == RX_STOP) && w_rx_last) begin
                r_rx_valid <= w_rx;
                r_rx_ferr  <= !w_rx;
            end
        end
    end

    // Reporting not-busy during the final stop-bit cycle lets the next start bit follow with no gap.
    assign w_tx_last = r_tx_busy && (r_tx_cnt == DIV_LAST) && (r_tx_nbit == 4'd9);
    assign o_tx_busy = r_tx_busy && !w_tx_last;
    assign w_tx_load = i_tx_start && !o_tx_busy;
    assign o_tx      = r_tx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_nbit  <= '0;
            r_tx_shift <= '1;
        end else if (w_tx_load) begin
            r_tx       <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_cnt   <= '0;
            r_tx_nbit  <= '0;
            r_tx_shift <= {1'b1, i_tx_data};
        end else if (r_tx_busy) begin
            if (r_tx_cnt == DIV_LAST) begin
                r_tx_cnt <= '0;
                if (r_tx_nbit == 4'd9) begin
                    r_tx_busy <= 1'b0;
                end else begin
                    r_tx       <= r_tx_shift[0];
                    r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                    r_tx_nbit  <= r_tx_nbit + 4'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dbg_uart_wb_bridge.sv
// Host debug bridge: UART command frames (cmd, addr[4], data[4]) become single
// Wishbone read/write cycles; results go back as ACK/NAK or four read bytes.
module dbg_uart_wb_bridge
    import dbg_bridge_pkg::*;
#(
    parameter int CLK_DIV    = 104,
    parameter int WB_TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        enable,
    input  logic        ser_rx,
    output logic        ser_tx,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy
);

    localparam int GAP_LIMIT = 16 * CLK_DIV;
    localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
    localparam int TO_W      = $clog2(WB_TIMEOUT + 1);

    logic             w_rx_valid;
    logic [7:0]       w_rx_data;
    logic             w_rx_ferr;
    logic             w_tx_busy;
    logic             w_tx_start;
    logic [7:0]       w_tx_data;

    state_t           r_state;
    state_t           w_next;
    logic             w_enter_wb;
    logic             w_gap_exp;
    logic             w_wb_to;
    logic             w_collect;

    logic             r_is_write;
    logic [1:0]       r_byte_cnt;
    logic [31:0]      r_adr;
    logic [31:0]      r_dat;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [TO_W-1:0]  r_wb_cnt;
    logic             r_cyc;
    logic             r_we;
    logic [3:0]       r_sel;
    logic [31:0]      r_resp;
    logic [2:0]       r_resp_left;

    dbg_uart_phy #(
        .CLK_DIV (CLK_DIV)
    ) u_phy (
        .i_clk      (wb_clk_i),
        .i_rst      (wb_rst_i),
        .i_rx       (ser_rx),
        .o_rx_valid (w_rx_valid),
        .o_rx_data  (w_rx_data),
        .o_rx_ferr  (w_rx_ferr),
        .i_tx_start (w_tx_start),
        .i_tx_data  (w_tx_data),
        .o_tx_busy  (w_tx_busy),
        .o_tx       (ser_tx)
    );

    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign busy      = (r_state != ST_IDLE);
    assign w_tx_data = r_resp[31:24];

    assign w_gap_exp = (r_gap_cnt == GAP_W'(GAP_LIMIT));
    assign w_wb_to   = r_cyc && !wbm_ack_i && (r_wb_cnt == TO_W'(WB_TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_enter_wb = 1'b0;
        w_tx_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_rx_valid && is_cmd(w_rx_data)) w_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (!enable || w_rx_ferr || w_gap_exp) begin
                    w_next = ST_IDLE;
                end else if (w_rx_valid && (r_byte_cnt == 2'd3)) begin
                    if (r_is_write) begin
                        w_next = ST_DATA;
                    end else begin
                        w_next     = ST_WB;
                        w_enter_wb = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (!enable || w_rx_ferr || w_gap_exp) begin
                    w_next = ST_IDLE;
                end else if (w_rx_valid && (r_byte_cnt == 2'd3)) begin
                    w_next     = ST_WB;
                    w_enter_wb = 1'b1;
                end
            end
            ST_WB: begin
                if (r_cyc && (wbm_ack_i || w_wb_to)) w_next = ST_RESP;
            end
            ST_RESP: begin
                if (!w_tx_busy) begin
                    if (r_resp_left != 3'd0) begin
                        w_tx_start = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_collect = ((r_state == ST_ADDR) || (r_state == ST_DATA)) && w_rx_valid && (w_next != ST_IDLE);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_is_write  <= 1'b0;
            r_byte_cnt  <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_gap_cnt   <= '0;
            r_wb_cnt    <= '0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_resp      <= '0;
            r_resp_left <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_byte_cnt <= '0;
                if (w_next == ST_ADDR) r_is_write <= (w_rx_data == CMD_WRITE);
            end
            if (w_collect) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (r_state == ST_ADDR) begin
                    r_adr <= {r_adr[23:0], w_rx_data};
                end else begin
                    r_dat <= {r_dat[23:0], w_rx_data};
                end
            end
            // Inter-byte silence is only policed while a command is partially received.
            if (((r_state == ST_ADDR) || (r_state == ST_DATA)) && !w_rx_valid && !w_rx_ferr) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end else begin
                r_gap_cnt <= '0;
            end
            if (w_enter_wb) begin
                r_cyc    <= 1'b1;
                r_we     <= r_is_write;
                r_sel    <= 4'hF;
                r_wb_cnt <= '0;
            end else if ((r_state == ST_WB) && r_cyc) begin
                if (wbm_ack_i) begin
                    r_cyc       <= 1'b0;
                    r_we        <= 1'b0;
                    r_sel       <= '0;
                    r_resp      <= r_is_write ? {RSP_ACK, 24'h0} : wbm_dat_i;
                    r_resp_left <= r_is_write ? 3'd1 : 3'd4;
                end else if (w_wb_to) begin
                    r_cyc       <= 1'b0;
                    r_we        <= 1'b0;
                    r_sel       <= '0;
                    r_resp      <= {RSP_NAK, 24'h0};
                    r_resp_left <= 3'd1;
                end else begin
                    r_wb_cnt <= r_wb_cnt + TO_W'(1);
                end
            end
            if (w_tx_start) begin
                r_resp      <= {r_resp[23:0], 8'h00};
                r_resp_left <= r_resp_left - 3'd1;
            end
        end
    end

endmodule

// File: doc/dbg_uart_wb_bridge.md
DBG_UART_WB_BRIDGE -- requirements
Module: dbg_uart_wb_bridge

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 104, giving wb_clk_i cycles per UART bit (12 MHz / 115200).
REQ-002 The block SHALL have parameter WB_TIMEOUT, default 255, giving the maximum wb_clk_i cycles to wait for wbm_ack_i.
REQ-003 The block SHALL have port wb_clk_i, input, width 1: the single clock.
REQ-004 The block SHALL have port wb_rst_i, input, width 1: reset, asynchronous, active-high.
REQ-005 The block SHALL have port enable, input, width 1: debug mode enable (debug_in).
REQ-006 The block SHALL have port ser_rx, input, width 1: UART receive from the host, idle high.
REQ-007 The block SHALL have port ser_tx, output, width 1: UART transmit to the host, idle high.
REQ-008 The block SHALL have ports wbm_cyc_o, wbm_stb_o and wbm_we_o, output, width 1 each: Wishbone master control.
REQ-009 The block SHALL have port wbm_sel_o, output, width 4: byte select, always 4'hF during a cycle.
REQ-010 The block SHALL have ports wbm_adr_o and wbm_dat_o, output, width 32 each: Wishbone address and write data.
REQ-011 The block SHALL have ports wbm_dat_i, input, width 32, and wbm_ack_i, input, width 1: Wishbone read data and acknowledge.
REQ-012 The block SHALL have port busy, output, width 1: high whenever the command FSM is not in IDLE.

Function
REQ-013 ser_rx SHALL pass through a 2-flop synchronizer, initialised to 1, before use.
REQ-014 RX SHALL detect a falling edge, recheck low at CLK_DIV/2, then sample 8 data bits LSB first at CLK_DIV intervals, then the stop bit.
REQ-015 A byte whose stop bit samples 0 SHALL be discarded (frame error), and the partial command SHALL be dropped with the FSM returning to IDLE.
REQ-016 Frame format SHALL be: cmd byte, then 4 address bytes MSB first, then, for writes only, 4 data bytes MSB first.
REQ-017 Cmd 8'h01 SHALL mean read and cmd 8'h02 SHALL mean write; any other cmd byte SHALL be ignored, with the FSM staying in IDLE and no response sent.
REQ-018 The FSM SHALL have the states IDLE, ADDR, DATA, WB, RESP.
REQ-019 FSM transitions SHALL be: IDLE->ADDR on a valid cmd; ADDR->DATA (write) or ADDR->WB (read) after the 4th address byte; DATA->WB after the 4th data byte; WB->RESP on ack or timeout; RESP->IDLE when the last TX byte's stop bit completes.
REQ-020 On WB entry, cyc and stb SHALL assert together in the next cycle, with we=1 for writes, and SHALL hold until the cycle in which wbm_ack_i=1 is sampled; both SHALL deassert the following cycle.
REQ-021 On a read ack, wbm_dat_i SHALL be latched on the ack cycle.
REQ-022 On timeout (WB_TIMEOUT cycles without ack), cyc and stb SHALL drop and the response SHALL be the single byte 8'h15 (NAK).
REQ-023 The read response SHALL be the 4 data bytes, MSB first.
REQ-024 The write response SHALL be the single byte 8'h06 (ACK).
REQ-025 TX format SHALL be 8N1, LSB first, at CLK_DIV per bit; consecutive response bytes SHALL be sent back-to-back, with a stop bit immediately followed by the next start bit.
REQ-026 If more than 16 bit times (16*CLK_DIV cycles) elapse between bytes while in ADDR or DATA, the partial command SHALL be dropped and the FSM SHALL return to IDLE.
REQ-027 Bytes received while in WB or RESP SHALL be discarded.
REQ-028 When enable=0 in IDLE, RX SHALL be ignored.
REQ-029 When enable falls in ADDR or DATA, the FSM SHALL go to IDLE.
REQ-030 When enable falls in WB or RESP, the operation SHALL complete normally.
REQ-031 Address and data SHALL be assembled by left shift, {reg[23:0], byte}.

Reset
REQ-032 While wb_rst_i=1: ser_tx=1, cyc/stb/we=0, sel=0, adr/dat_o=0, busy=0, FSM=IDLE, all counters=0, synchronizer=2'b11.
REQ-033 Reset asserted mid-transaction SHALL abort immediately, dropping cyc and returning ser_tx high within the same cycle (asynchronous).

Structure
REQ-034 Package dbg_bridge_pkg SHALL hold the FSM state enum, CMD_READ=8'h01, CMD_WRITE=8'h02, RSP_ACK=8'h06, RSP_NAK=8'h15.
REQ-035 One sub-module, dbg_uart_phy, SHALL hold the RX/TX serialisers with rx_valid/rx_data/rx_ferr and tx_start/tx_data/tx_busy handshakes.

Verification
REQ-036 Write test: with enable=1, send 02 30 00 00 04 00 00 AB 00 and slave acks after 3 cycles -> exactly one WB write, adr=32'h3000_0004, dat=32'h0000_AB00, sel=F; ser_tx returns 06.
REQ-037 Read test: send 01 30 00 00 04, slave returns 32'hDEAD_BEEF -> ser_tx emits DE AD BE EF back-to-back.
REQ-038 Timeout test: read with no ack -> cyc high exactly 255 cycles then low; ser_tx emits 15.
REQ-039 Framing test: send 7F (ignored); a byte with stop bit=0 mid-address; an 18-bit-time gap after 2 address bytes -> no WB cycle, no TX, busy=0 afterward.
REQ-040 Enable/reset test: enable=0 while sending a valid write -> no WB cycle; wb_rst_i pulse during cyc -> cyc=0 immediately, next valid command works.
